deparser_layer: RTL and testbench
=================================

Name: deparser_layer

Overview:
- Deparses one protocol layer, the inverse of a parser layer.
- Takes the partially rebuilt header, the metadata stack of extracted key fields, and a protocol tag. It opens room at the front of the header, then writes the layer's key fields back at rule-defined offsets.
- Layers are chained in reverse parse order to rebuild the packet header.
- Owns its rule table: write and read-back through the 32-bit rule port shared with the parser layers.

Parameters:
- LAYER_ID, 0: matched against i_rule_addr[31:8] to select this layer.
- HEAD_WIDTH, 1024: header bits; MSB is the first byte on the wire.
- META_WIDTH, 512: metadata stack bits; top field at the MSB.
- FIELD_WIDTH, 16: key field width; also the offset/shift unit.
- FIELD_NUM, 8: key fields consumed per layer.
- OFFSET_WIDTH, 6: slot index in FIELD_WIDTH units (64 slots).
- TAG_WIDTH, 4: protocol tag width.
- RULE_NUM, 4: rule entries; at most 16.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_rule_wren  in  1  rule write strobe
- i_rule_rden  in  1  rule read strobe
- i_rule_addr  in  32  rule address
- i_rule_wdata  in  32  rule write data
- o_rule_rdata_valid  out  1  read data valid
- o_rule_rdata  out  32  read data
- i_valid  in  1  input beat valid
- i_tag  in  TAG_WIDTH  protocol tag of this layer
- i_head  in  HEAD_WIDTH  header rebuilt so far
- i_meta  in  META_WIDTH  metadata stack
- o_valid  out  1  output beat valid
- o_tag  out  TAG_WIDTH  tag for the next layer
- o_head  out  HEAD_WIDTH  rebuilt header
- o_meta  out  META_WIDTH  remaining metadata
- o_miss  out  1  no rule matched

Behaviour:
- Reset (synchronous, active-low):
  - all rule entries cleared, including valid;
  - every output is 0 on the cycle after reset is asserted;
  - beats in flight are dropped.
- Rule address decode: selected when i_rule_addr[31:8]==LAYER_ID; rule index = addr[7:4]; word = addr[1:0].
- Rule words:
  - word0: [31] valid, [27:24] nextTag, [19:16] tag, [13:8] headShift.
  - word1: field slots 0..3; word2: field slots 4..7. Slot i occupies [7i+6:7i] as {en, offset[5:0]}.
  - Unused bits read as 0. Word 3 and rule index >= RULE_NUM: writes ignored, reads return 0.
- Rule write: takes effect for lookups starting the next cycle.
- Rule read:
  - o_rule_rdata_valid asserts 1 cycle after i_rule_rden, and only when the address is selected; otherwise it stays 0.
  - A read and a write to the same address in the same cycle return the old value.
- Pipeline: fixed latency 2, no backpressure, one beat per cycle accepted.
  - Data registers capture their inputs every cycle.
  - o_valid is i_valid delayed by 2.
- Stage 1 (registered), lookup:
  - hit = lowest-index valid rule with rule.tag==i_tag.
  - On hit: head_s1 = i_head >> (headShift*FIELD_WIDTH), zero-filled at the front (MSB side).
  - Fields: field[i] = i_meta[META_WIDTH-1-i*FIELD_WIDTH -: FIELD_WIDTH].
  - meta_s1 = i_meta << (FIELD_NUM*FIELD_WIDTH), zero-filled.
  - tag_s1 = rule.nextTag.
- Stage 2 (registered), write-back:
  - For each enabled slot i: o_head[HEAD_WIDTH-1-offset*FIELD_WIDTH -: FIELD_WIDTH] = field[i].
  - Two slots with the same offset: the higher slot index wins.
  - Disabled slots discard their field.
- Miss: o_head=i_head, o_meta=i_meta, o_tag=i_tag, o_miss=1, all delayed by 2. No shift and no writes.
- Reset mid-operation: in-flight beats are discarded; o_valid=0 until new input has propagated.
- headShift=0 is legal: fields are overwritten in place.

Decomposition:
- Additions to parser_pkg:
  - typedef deparse_rule_t {valid, nextTag, tag, headShift, slot_en[FIELD_NUM], slot_off[FIELD_NUM]};
  - typedef deparse_info_t {valid, tag, head, meta};
  - constants DEPARSE_WORD0/1/2 for the rule word map.
- One sub-module: deparse_rule_table.
  - Holds the rule registers and handles write/read.
  - Provides the combinational first-match lookup: hit, index, rule.

Test Plan:
- Reset, then i_valid=1 with no rules written: 2 cycles later o_valid=1, o_miss=1, and head/meta/tag equal the inputs.
- Rule 0 = {valid, tag=1, nextTag=2, headShift=7, slots 0..6 at offsets 0..6, slot 7 disabled}; i_tag=1, i_head=all 0xFF, meta top fields 0x0001..0x0008. Expect:
  - o_head top 112 bits = 0x0001..0x0007;
  - remaining bits are i_head shifted right 112;
  - o_tag=2, o_miss=0;
  - o_meta = i_meta<<128.
- Rules 0 and 2 both with tag=3: the lookup uses rule 0's shift and nextTag. Two slots both at offset 5: the higher slot's field appears.
- Write word1 of rule 1 = 0x0000_0083, then read it back: rdata=0x0000_0083 one cycle later. Read with addr[31:8]!=LAYER_ID: no rdata_valid.
- Back-to-back beats while rule 0 is rewritten mid-stream: beats issued before the write use the old rule; beats issued the cycle after use the new rule.
- Assert i_rst_n=0 with 2 beats in flight: o_valid=0 the next cycle, rule reads return 0, and later beats all miss.

Source files
------------

// File: rtl/deparser_layer_pkg.sv
// Shared types and constants for the header deparser layer.
// The rule word map lives here so the table and any software model agree on it.
package deparser_layer_pkg;

  localparam int DP_FIELD_NUM    = 8;
  localparam int DP_OFFSET_WIDTH = 6;
  localparam int DP_TAG_WIDTH    = 4;
  localparam int DP_HEAD_WIDTH   = 1024;
  localparam int DP_META_WIDTH   = 512;

  localparam logic [1:0] DEPARSE_WORD0 = 2'd0;
  localparam logic [1:0] DEPARSE_WORD1 = 2'd1;
  localparam logic [1:0] DEPARSE_WORD2 = 2'd2;

  typedef struct packed {
    logic                                           valid;
    logic [DP_TAG_WIDTH-1:0]                        next_tag;
    logic [DP_TAG_WIDTH-1:0]                        tag;
    logic [DP_OFFSET_WIDTH-1:0]                     head_shift;
    logic [DP_FIELD_NUM-1:0]                        slot_en;
    logic [DP_FIELD_NUM-1:0][DP_OFFSET_WIDTH-1:0]   slot_off;
  } deparse_rule_t;

  typedef struct packed {
    logic                     valid;
    logic [DP_TAG_WIDTH-1:0]  tag;
    logic [DP_HEAD_WIDTH-1:0] head;
    logic [DP_META_WIDTH-1:0] meta;
  } deparse_info_t;

  // Packs one rule into its 32-bit read-back word; unmapped bits and word 3 read 0.
  function automatic logic [31:0] rule_word(input deparse_rule_t r, input logic [1:0] word);
    logic [31:0] w;
    w = 32'h0000_0000;
    case (word)
      DEPARSE_WORD0: begin
        w[31]    = r.valid;
        w[27:24] = r.next_tag;
        w[19:16] = r.tag;
        w[13:8]  = r.head_shift;
      end
      DEPARSE_WORD1: begin
        for (int i = 0; i < 4; i++) w[7*i +: 7] = {r.slot_en[i], r.slot_off[i]};
      end
      DEPARSE_WORD2: begin
        for (int i = 0; i < 4; i++) w[7*i +: 7] = {r.slot_en[i+4], r.slot_off[i+4]};
      end
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/deparse_rule_table.sv
// Rule registers for one deparser layer: 32-bit write/read-back port and
// combinational first-match lookup on the protocol tag.
module deparse_rule_table
  import deparser_layer_pkg::*;
#(
  parameter int LAYER_ID = 0,
  parameter int RULE_NUM = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_rule_wren,
  input  logic                    i_rule_rden,
  input  logic [31:0]             i_rule_addr,
  input  logic [31:0]             i_rule_wdata,
  output logic                    o_rule_rdata_valid,
  output logic [31:0]             o_rule_rdata,
  input  logic [DP_TAG_WIDTH-1:0] i_tag,
  output logic                    o_hit,
  output deparse_rule_t           o_rule
);

  deparse_rule_t rule_r [RULE_NUM];
  logic          sel_s;
  logic [3:0]    idx_s;
  logic [1:0]    word_s;
  logic [31:0]   rdata_s;
  logic          unused_s;

  assign sel_s    = (i_rule_addr[31:8] == 24'(LAYER_ID));
  assign idx_s    = i_rule_addr[7:4];
  assign word_s   = i_rule_addr[1:0];
  assign unused_s = ^{i_rule_addr[3:2], i_rule_wdata[30:28]};

  // Rule register writes; out-of-range index and word 3 match nothing and are dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int r = 0; r < RULE_NUM; r++) rule_r[r] <= '0;
    end else begin
      for (int r = 0; r < RULE_NUM; r++) begin
        if (i_rule_wren && sel_s && (idx_s == 4'(r))) begin
          case (word_s)
            DEPARSE_WORD0: begin
              rule_r[r].valid      <= i_rule_wdata[31];
              rule_r[r].next_tag   <= i_rule_wdata[27:24];
              rule_r[r].tag        <= i_rule_wdata[19:16];
              rule_r[r].head_shift <= i_rule_wdata[13:8];
            end
            DEPARSE_WORD1: begin
              for (int i = 0; i < 4; i++) begin
                rule_r[r].slot_en[i]  <= i_rule_wdata[7*i+6];
                rule_r[r].slot_off[i] <= i_rule_wdata[7*i +: 6];
              end
            end
            DEPARSE_WORD2: begin
              for (int i = 0; i < 4; i++) begin
                rule_r[r].slot_en[i+4]  <= i_rule_wdata[7*i+6];
                rule_r[r].slot_off[i+4] <= i_rule_wdata[7*i +: 6];
              end
            end
            default: rule_r[r] <= rule_r[r];
          endcase
        end else begin
          rule_r[r] <= rule_r[r];
        end
      end
    end
  end

  // Read mux; indices without a rule entry return 0.
  always_comb begin
    rdata_s = 32'h0000_0000;
    for (int r = 0; r < RULE_NUM; r++) begin
      if (idx_s == 4'(r)) rdata_s = rule_word(rule_r[r], word_s);
      else                rdata_s = rdata_s;
    end
  end

  // Registered read-back; a same-cycle write is not yet visible, so old data returns.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rule_rdata_valid <= 1'b0;
      o_rule_rdata       <= 32'h0000_0000;
    end else begin
      o_rule_rdata_valid <= i_rule_rden && sel_s;
      o_rule_rdata       <= (i_rule_rden && sel_s) ? rdata_s : 32'h0000_0000;
    end
  end

  // First match wins: scan downward so the lowest matching index is kept last.
  always_comb begin
    o_hit  = 1'b0;
    o_rule = '0;
    for (int r = RULE_NUM - 1; r >= 0; r--) begin
      if (rule_r[r].valid && (rule_r[r].tag == i_tag)) begin
        o_hit  = 1'b1;
        o_rule = rule_r[r];
      end else begin
        o_hit  = o_hit;
        o_rule = o_rule;
      end
    end
  end

endmodule

// File: rtl/deparser_layer.sv
// One deparser layer: opens headShift fields at the front of the header, then
// writes the layer's key fields back at rule-defined slots. Latency 2, no stalls.
module deparser_layer
  import deparser_layer_pkg::*;
#(
  parameter int LAYER_ID     = 0,
  parameter int HEAD_WIDTH   = DP_HEAD_WIDTH,
  parameter int META_WIDTH   = DP_META_WIDTH,
  parameter int FIELD_WIDTH  = 16,
  parameter int FIELD_NUM    = DP_FIELD_NUM,
  parameter int OFFSET_WIDTH = DP_OFFSET_WIDTH,
  parameter int TAG_WIDTH    = DP_TAG_WIDTH,
  parameter int RULE_NUM     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rule_wren,
  input  logic                  i_rule_rden,
  input  logic [31:0]           i_rule_addr,
  input  logic [31:0]           i_rule_wdata,
  output logic                  o_rule_rdata_valid,
  output logic [31:0]           o_rule_rdata,
  input  logic                  i_valid,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  input  logic [HEAD_WIDTH-1:0] i_head,
  input  logic [META_WIDTH-1:0] i_meta,
  output logic                  o_valid,
  output logic [TAG_WIDTH-1:0]  o_tag,
  output logic [HEAD_WIDTH-1:0] o_head,
  output logic [META_WIDTH-1:0] o_meta,
  output logic                  o_miss
);

  logic          hit_s;
  deparse_rule_t rule_s;
  logic          unused_rule_s;

  deparse_rule_table #(
    .LAYER_ID (LAYER_ID),
    .RULE_NUM (RULE_NUM)
  ) u_rule_table (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_rule_wren        (i_rule_wren),
    .i_rule_rden        (i_rule_rden),
    .i_rule_addr        (i_rule_addr),
    .i_rule_wdata       (i_rule_wdata),
    .o_rule_rdata_valid (o_rule_rdata_valid),
    .o_rule_rdata       (o_rule_rdata),
    .i_tag              (i_tag),
    .o_hit              (hit_s),
    .o_rule             (rule_s)
  );

  assign unused_rule_s = ^{rule_s.valid, rule_s.tag};

  deparse_info_t                                info_s;
  deparse_info_t                                s1_info_r;
  logic [15:0]                                  shamt_s;
  logic [FIELD_NUM-1:0][FIELD_WIDTH-1:0]        field_s;
  logic [FIELD_NUM-1:0][FIELD_WIDTH-1:0]        s1_field_r;
  logic [FIELD_NUM-1:0]                         en_s;
  logic [FIELD_NUM-1:0]                         s1_en_r;
  logic [FIELD_NUM-1:0][OFFSET_WIDTH-1:0]       s1_off_r;
  logic                                         s1_hit_r;
  logic [HEAD_WIDTH-1:0]                        head_wb_s;

  // Stage-1 next state: shift header and pop fields on a hit, pass through on a miss.
  always_comb begin
    shamt_s = 16'(rule_s.head_shift) * 16'(FIELD_WIDTH);
    for (int i = 0; i < FIELD_NUM; i++) begin
      field_s[i] = i_meta[META_WIDTH-1-i*FIELD_WIDTH -: FIELD_WIDTH];
    end
    info_s.valid = i_valid;
    if (hit_s) begin
      info_s.tag  = rule_s.next_tag;
      info_s.head = i_head >> shamt_s;
      info_s.meta = i_meta << (FIELD_NUM * FIELD_WIDTH);
      en_s        = rule_s.slot_en;
    end else begin
      info_s.tag  = i_tag;
      info_s.head = i_head;
      info_s.meta = i_meta;
      en_s        = '0;
    end
  end

  // Stage-1 registers; data captures every cycle regardless of valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_info_r  <= '0;
      s1_field_r <= '0;
      s1_en_r    <= '0;
      s1_off_r   <= '0;
      s1_hit_r   <= 1'b0;
    end else begin
      s1_info_r  <= info_s;
      s1_field_r <= field_s;
      s1_en_r    <= en_s;
      s1_off_r   <= rule_s.slot_off;
      s1_hit_r   <= hit_s;
    end
  end

  // Write-back in ascending slot order so the higher slot wins a shared offset.
  always_comb begin
    head_wb_s = s1_info_r.head;
    for (int i = 0; i < FIELD_NUM; i++) begin
      if (s1_en_r[i]) begin
        head_wb_s[HEAD_WIDTH-1-int'(s1_off_r[i])*FIELD_WIDTH -: FIELD_WIDTH] = s1_field_r[i];
      end else begin
        head_wb_s = head_wb_s;
      end
    end
  end

  // Stage-2 output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_tag   <= '0;
      o_head  <= '0;
      o_meta  <= '0;
      o_miss  <= 1'b0;
    end else begin
      o_valid <= s1_info_r.valid;
      o_tag   <= s1_info_r.tag;
      o_head  <= head_wb_s;
      o_meta  <= s1_info_r.meta;
      o_miss  <= s1_info_r.valid & ~s1_hit_r;
    end
  end

endmodule

// File: tb/tb_deparser_layer.sv
// Randomized bench for deparser_layer against a rule-word-level reference model
// with a two-deep expected-output pipeline.
module tb_deparser_layer;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rule_wren, rule_rden;
  logic [31:0]   rule_addr, rule_wdata;
  logic          rdv;
  logic [31:0]   rdata;
  logic          valid;
  logic [3:0]    tag;
  logic [1023:0] head;
  logic [511:0]  meta;
  logic          o_valid, o_miss;
  logic [3:0]    o_tag;
  logic [1023:0] o_head;
  logic [511:0]  o_meta;

  int tests_run    = 0;
  int tests_failed = 0;

  deparser_layer #(.LAYER_ID(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rule_wren(rule_wren), .i_rule_rden(rule_rden),
    .i_rule_addr(rule_addr), .i_rule_wdata(rule_wdata),
    .o_rule_rdata_valid(rdv), .o_rule_rdata(rdata),
    .i_valid(valid), .i_tag(tag), .i_head(head), .i_meta(meta),
    .o_valid(o_valid), .o_tag(o_tag), .o_head(o_head), .o_meta(o_meta),
    .o_miss(o_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    bit [3:0]    tag;
    bit [1023:0] head;
    bit [511:0]  meta;
    bit          miss;
  } beat_t;

  bit [31:0] mem [4][3];
  beat_t     p1, p2;

  function automatic bit [1023:0] rand_head();
    bit [1023:0] h;
    for (int i = 0; i < 32; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction

  function automatic bit [511:0] rand_meta();
    bit [511:0] m;
    for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
    return m;
  endfunction

  function automatic int first_diff(input bit [1023:0] a, input bit [1023:0] b);
    for (int k = 0; k < 64; k++) if (a[1023-16*k -: 16] != b[1023-16*k -: 16]) return k;
    return -1;
  endfunction

  // Expected result of one beat from the currently stored rule words.
  function automatic beat_t model_beat(input bit v, input bit [3:0] t,
                                       input bit [1023:0] h, input bit [511:0] m);
    beat_t     b;
    int        hit;
    bit [31:0] w;
    bit [6:0]  s;
    hit = -1;
    b.valid = v; b.tag = t; b.head = h; b.meta = m; b.miss = v;
    for (int r = 3; r >= 0; r--) if (mem[r][0][31] && mem[r][0][19:16] == t) hit = r;
    if (hit >= 0) begin
      b.head = h >> (mem[hit][0][13:8] * 16);
      for (int i = 0; i < 8; i++) begin
        w = (i < 4) ? mem[hit][1] : mem[hit][2];
        s = w[7*(i%4) +: 7];
        if (s[6]) b.head[1023 - s[5:0]*16 -: 16] = m[511-16*i -: 16];
      end
      b.meta = m << 128;
      b.tag  = mem[hit][0][27:24];
      b.miss = 1'b0;
    end
    return b;
  endfunction

  // Advance one clock, keeping the model in step; outputs are valid to sample on return.
  task automatic step();
    beat_t nb;
    int    idx, wd;
    bit    sel;
    sel = (rule_addr[31:8] == 24'd0);
    idx = int'(rule_addr[7:4]);
    wd  = int'(rule_addr[1:0]);
    nb  = '{default: 0};
    if (!rst_n) begin
      foreach (mem[r, k]) mem[r][k] = 32'h0;
    end else begin
      nb = model_beat(valid, tag, head, meta);
      if (rule_wren && sel && idx < 4 && wd < 3)
        mem[idx][wd] = rule_wdata & ((wd == 0) ? 32'h8F0F_3F00 : 32'h0FFF_FFFF);
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      p1 = '{default: 0};
      p2 = '{default: 0};
    end else begin
      p2 = p1;
      p1 = nb;
    end
  endtask

  task automatic wr(input int idx, input int word, input bit [31:0] d);
    rule_wren  = 1'b1;
    rule_addr  = {24'd0, 4'(idx), 2'b00, 2'(word)};
    rule_wdata = d;
    step();
    rule_wren  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b1; tag = 4'h1; head = rand_head(); meta = rand_meta();
    step();
    tests_run++;
    if ({o_valid, o_miss, o_tag, rdv, rdata} !== 39'd0 || o_head !== '0 || o_meta !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs act valid=%b miss=%b tag=%h rdv=%b rdata=%h exp all 0",
               o_valid, o_miss, o_tag, rdv, rdata);
    end
    rst_n = 1'b1; valid = 1'b0;
    step();
  endtask

  task automatic test_miss_no_rules();
    bit [1023:0] h; bit [511:0] m; bit [3:0] t;
    h = rand_head(); m = rand_meta(); t = 4'($urandom_range(0, 15));
    valid = 1'b1; tag = t; head = h; meta = m;
    step();
    valid = 1'b0; head = rand_head(); meta = rand_meta();
    step();
    tests_run++;
    if (o_valid !== 1'b1 || o_miss !== 1'b1 || o_tag !== t) begin
      tests_failed++;
      $display("FAIL miss_ctrl act valid=%b miss=%b tag=%h exp 1 1 %h", o_valid, o_miss, o_tag, t);
    end
    tests_run++;
    if (o_head !== h || o_meta !== m) begin
      tests_failed++;
      $display("FAIL miss_data first differing head field %0d, meta act=%h exp=%h",
               first_diff(o_head, h), o_meta, m);
    end
  endtask

  task automatic test_rule_hit();
    bit [31:0] w1, w2; bit [111:0] et; bit [511:0] m;
    w1 = 32'h0; w2 = 32'h0;
    for (int i = 0; i < 4; i++) w1[7*i +: 7] = {1'b1, 6'(i)};
    for (int i = 0; i < 3; i++) w2[7*i +: 7] = {1'b1, 6'(i + 4)};
    valid = 1'b0;
    wr(0, 0, 32'h8201_0700);
    wr(0, 1, w1);
    wr(0, 2, w2);
    m = rand_meta();
    for (int k = 0; k < 8; k++) m[511-16*k -: 16] = 16'(k + 1);
    for (int k = 0; k < 7; k++) et[111-16*k -: 16] = 16'(k + 1);
    valid = 1'b1; tag = 4'h1; head = {1024{1'b1}}; meta = m;
    step();
    valid = 1'b0;
    step();
    tests_run++;
    if (o_head[1023:912] !== et) begin
      tests_failed++;
      $display("FAIL hit_fields act=%h exp=%h", o_head[1023:912], et);
    end
    tests_run++;
    if (o_head[911:0] !== {912{1'b1}}) begin
      tests_failed++;
      $display("FAIL hit_shift act low field=%h exp all ones", o_head[15:0]);
    end
    tests_run++;
    if (o_valid !== 1'b1 || o_tag !== 4'h2 || o_miss !== 1'b0 || o_meta !== (m << 128)) begin
      tests_failed++;
      $display("FAIL hit_ctrl act valid=%b tag=%h miss=%b meta=%h exp 1 2 0 shifted",
               o_valid, o_tag, o_miss, o_meta);
    end
    // random beats through the same rule set
    for (int i = 0; i < 22; i++) begin
      valid = (i < 20) ? 1'($urandom) : 1'b0;
      tag = 4'($urandom_range(0, 3)); head = rand_head(); meta = rand_meta();
      step();
      tests_run++;
      if (o_valid !== p2.valid || (p2.valid && (o_tag !== p2.tag || o_miss !== p2.miss))) begin
        tests_failed++;
        $display("FAIL hit_rand_ctrl cyc %0d act %b/%h/%b exp %b/%h/%b",
                 i, o_valid, o_tag, o_miss, p2.valid, p2.tag, p2.miss);
      end
      if (p2.valid) begin
        tests_run++;
        if (o_head !== p2.head || o_meta !== p2.meta) begin
          tests_failed++;
          $display("FAIL hit_rand_data cyc %0d head field %0d act=%h exp=%h",
                   i, first_diff(o_head, p2.head), o_head[1023 -: 64], p2.head[1023 -: 64]);
        end
      end
    end
  endtask

  task automatic test_priority_overlap();
    bit [511:0] m;
    valid = 1'b0;
    wr(2, 0, 32'h8903_0400);
    wr(2, 1, 32'h0000_0040);
    wr(0, 0, 32'h8503_0200);
    wr(0, 1, (32'h45 << 7) | (32'h45 << 21));
    wr(0, 2, 32'h0);
    m = rand_meta();
    valid = 1'b1; tag = 4'h3; head = rand_head(); meta = m;
    step();
    valid = 1'b0;
    step();
    tests_run++;
    if (o_tag !== 4'h5 || o_miss !== 1'b0 || o_head[1023 -: 32] !== 32'h0) begin
      tests_failed++;
      $display("FAIL prio_rule act tag=%h miss=%b front=%h exp 5 0 00000000",
               o_tag, o_miss, o_head[1023 -: 32]);
    end
    tests_run++;
    if (o_head[1023-80 -: 16] !== m[511-48 -: 16]) begin
      tests_failed++;
      $display("FAIL prio_same_offset act=%h exp=%h", o_head[1023-80 -: 16], m[511-48 -: 16]);
    end
    tests_run++;
    if (o_head !== p2.head) begin
      tests_failed++;
      $display("FAIL prio_head field %0d differs", first_diff(o_head, p2.head));
    end
  endtask

  task automatic test_rule_port();
    valid = 1'b0;
    wr(1, 1, 32'h0000_0083);
    rule_rden = 1'b1; rule_addr = 32'h0000_0011;
    step();
    tests_run++;
    if (rdv !== 1'b1 || rdata !== 32'h0000_0083) begin
      tests_failed++;
      $display("FAIL rd_word1 act rdv=%b rdata=%h exp 1 00000083", rdv, rdata);
    end
    rule_addr = 32'h0000_0111;
    step();
    tests_run++;
    if (rdv !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_other_layer act rdv=%b exp 0", rdv);
    end
    rule_rden = 1'b0;
    wr(5, 0, 32'hFFFF_FFFF);
    rule_rden = 1'b1; rule_addr = 32'h0000_0050;
    step();
    tests_run++;
    if (rdv !== 1'b1 || rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL rd_bad_index act rdv=%b rdata=%h exp 1 00000000", rdv, rdata);
    end
    rule_rden = 1'b0;
    wr(3, 0, 32'hFFFF_FFFF);
    rule_rden = 1'b1; rule_addr = 32'h0000_0030;
    step();
    tests_run++;
    if (rdata !== 32'h8F0F_3F00) begin
      tests_failed++;
      $display("FAIL rd_word0_mask act=%h exp=8f0f3f00", rdata);
    end
    rule_addr = 32'h0000_0013;
    step();
    tests_run++;
    if (rdv !== 1'b1 || rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL rd_word3 act rdv=%b rdata=%h exp 1 00000000", rdv, rdata);
    end
    rule_wren = 1'b1; rule_addr = 32'h0000_0011; rule_wdata = 32'h0000_0005;
    step();
    rule_wren = 1'b0;
    tests_run++;
    if (rdata !== 32'h0000_0083) begin
      tests_failed++;
      $display("FAIL rd_during_wr act=%h exp=00000083", rdata);
    end
    step();
    rule_rden = 1'b0;
    tests_run++;
    if (rdata !== 32'h0000_0005) begin
      tests_failed++;
      $display("FAIL rd_after_wr act=%h exp=00000005", rdata);
    end
  endtask

  task automatic test_back_to_back();
    bit [3:0] tags [4] = '{4'h3, 4'h1, 4'hF, 4'h3};
    for (int i = 0; i < 32; i++) begin
      valid = (i < 30);
      tag = tags[$urandom_range(0, 3)]; head = rand_head(); meta = rand_meta();
      rule_addr = 32'h0000_0000; rule_wren = 1'b0;
      if (i == 10) begin
        rule_wren = 1'b1; rule_addr = 32'h0000_0000;
        rule_wdata = 32'h8003_0000 | ($urandom & 32'h0F00_3F00);
      end else if (i == 20) begin
        rule_wren = 1'b1; rule_addr = 32'h0000_0001; rule_wdata = $urandom;
      end
      step();
      tests_run++;
      if (o_valid !== p2.valid || (p2.valid && (o_tag !== p2.tag || o_miss !== p2.miss))) begin
        tests_failed++;
        $display("FAIL b2b_ctrl cyc %0d act %b/%h/%b exp %b/%h/%b",
                 i, o_valid, o_tag, o_miss, p2.valid, p2.tag, p2.miss);
      end
      if (p2.valid) begin
        tests_run++;
        if (o_head !== p2.head || o_meta !== p2.meta) begin
          tests_failed++;
          $display("FAIL b2b_data cyc %0d head field %0d act=%h exp=%h",
                   i, first_diff(o_head, p2.head), o_head[1023 -: 64], p2.head[1023 -: 64]);
        end
      end
    end
    rule_wren = 1'b0;
  endtask

  task automatic test_reset_midflight();
    valid = 1'b1; tag = 4'h3;
    step();
    head = rand_head();
    step();
    rst_n = 1'b0; valid = 1'b0;
    step();
    tests_run++;
    if (o_valid !== 1'b0 || o_head !== '0) begin
      tests_failed++;
      $display("FAIL rst_flight act valid=%b head_top=%h exp 0 0", o_valid, o_head[1023 -: 32]);
    end
    rst_n = 1'b1;
    rule_rden = 1'b1; rule_addr = 32'h0000_0000;
    step();
    rule_rden = 1'b0;
    tests_run++;
    if (o_valid !== 1'b0 || rdv !== 1'b1 || rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_rules act valid=%b rdv=%b rdata=%h exp 0 1 00000000", o_valid, rdv, rdata);
    end
    for (int i = 0; i < 8; i++) begin
      valid = (i < 6); tag = (i % 2 == 0) ? 4'h3 : 4'h1; head = rand_head(); meta = rand_meta();
      step();
      if (p2.valid) begin
        tests_run++;
        if (o_valid !== 1'b1 || o_miss !== 1'b1 || o_tag !== p2.tag ||
            o_head !== p2.head || o_meta !== p2.meta) begin
          tests_failed++;
          $display("FAIL rst_later_miss cyc %0d act valid=%b miss=%b tag=%h exp 1 1 %h",
                   i, o_valid, o_miss, o_tag, p2.tag);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rule_wren = 1'b0; rule_rden = 1'b0;
    rule_addr = 32'h0; rule_wdata = 32'h0;
    valid = 1'b0; tag = 4'h0; head = '0; meta = '0;
    p1 = '{default: 0}; p2 = '{default: 0};
    test_reset();
    test_miss_no_rules();
    test_rule_hit();
    test_priority_overlap();
    test_rule_port();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
